// File: rtl/port_arb_pkg.sv
// Shared types and constants for the four-port round-robin grant arbiter.
// The HOLD_MAX default is used only when ARB_TIMEOUT_EN is defined.
package port_arb_pkg;

    localparam int NUM_REQ          = 4;
    localparam int ID_W             = 2;
    localparam int HOLD_CNT_W       = 8;
    localparam int HOLD_MAX_DEFAULT = 255;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_RECOVER = 2'd2
    } arb_state_e;

    function automatic logic [NUM_REQ-1:0] id_to_onehot(input logic [ID_W-1:0] id);
        id_to_onehot = NUM_REQ'(1) << id;
    endfunction

endpackage

// File: rtl/port_arbiter4_rr_pick4.sv
// Rotating-priority picker: scans req upward from last_id+1 (mod 4) and
// returns the first requester found. Purely combinational.
module rr_pick4
    import port_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    last_id,
    output logic               valid,
    output logic [ID_W-1:0]    winner_id
);

    logic [ID_W-1:0] idx;

    // i == NUM_REQ wraps back to last_id itself, so it gets lowest priority.
    always_comb begin
        valid     = 1'b0;
        winner_id = '0;
        idx       = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = last_id + ID_W'(i);
            if (!valid && req[idx]) begin
                valid     = 1'b1;
                winner_id = idx;
            end
        end
    end

endmodule

// File: rtl/port_arbiter4.sv
// Four-port round-robin arbiter with registered one-hot grant.
// Define ARB_TIMEOUT_EN to add the hold counter, HOLD_MAX and the timeout pulse.
//
// state      | meaning
// ST_IDLE    | no grant; evaluate req unless inhibit is high
// ST_GRANT   | gnt held until rel[gnt_id] (or hold timeout)
// ST_RECOVER | one dead cycle after release, requests ignored
module port_arbiter4
    import port_arb_pkg::*;
`ifdef ARB_TIMEOUT_EN
#(
    parameter int HOLD_MAX = HOLD_MAX_DEFAULT
)
`endif
(
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] rel,
    input  logic               inhibit,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    gnt_id,
    output logic               busy
`ifdef ARB_TIMEOUT_EN
    ,
    output logic               timeout
`endif
);

    arb_state_e      state;
    logic [ID_W-1:0] last_id;
    logic            pick_valid;
    logic [ID_W-1:0] pick_id;
    logic            rel_valid;

`ifdef ARB_TIMEOUT_EN
    localparam logic [HOLD_CNT_W-1:0] HOLD_LAST = HOLD_CNT_W'(HOLD_MAX - 1);
    logic [HOLD_CNT_W-1:0] hold_cnt;
`endif

    rr_pick4 u_pick (
        .req       (req),
        .last_id   (last_id),
        .valid     (pick_valid),
        .winner_id (pick_id)
    );

    assign rel_valid = rel[gnt_id];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state   <= ST_IDLE;
            gnt     <= '0;
            gnt_id  <= '0;
            busy    <= 1'b0;
            last_id <= ID_W'(NUM_REQ - 1);
`ifdef ARB_TIMEOUT_EN
            hold_cnt <= '0;
            timeout  <= 1'b0;
`endif
        end else begin
`ifdef ARB_TIMEOUT_EN
            timeout <= 1'b0;
`endif
            case (state)
                ST_IDLE: begin
                    if (!inhibit && pick_valid) begin
                        gnt    <= id_to_onehot(pick_id);
                        gnt_id <= pick_id;
                        busy   <= 1'b1;
                        state  <= ST_GRANT;
`ifdef ARB_TIMEOUT_EN
                        hold_cnt <= '0;
`endif
                    end else begin
                        gnt  <= '0;
                        busy <= 1'b0;
                    end
                end
                ST_GRANT: begin
                    // A valid release wins over a coincident timeout.
                    if (rel_valid) begin
                        gnt     <= '0;
                        last_id <= gnt_id;
                        state   <= ST_RECOVER;
                    end
`ifdef ARB_TIMEOUT_EN
                    else if (hold_cnt == HOLD_LAST) begin
                        gnt     <= '0;
                        last_id <= gnt_id;
                        state   <= ST_RECOVER;
                        timeout <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt + HOLD_CNT_W'(1);
                    end
`endif
                end
                ST_RECOVER: begin
                    gnt   <= '0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    gnt   <= '0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/port_arbiter4.md
PORT_ARBITER4 -- requirements
Module: port_arbiter4

Interface
REQ-001 Parameter: HOLD_MAX, 255, maximum cycles a grant is held before forced revoke (timeout build only), range 2..255.
REQ-002 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 Port: reset_n  input  1  reset, synchronous, active-low.
REQ-004 Port: req  input  4  request lines, one per requester; level-sensitive.
REQ-005 Port: rel  input  4  release strobes; only rel[gnt_id] is honoured.
REQ-006 Port: inhibit  input  1  when high, no new grant is issued.
REQ-007 Port: gnt  output  4  one-hot grant, registered; all-zero when no grant.
REQ-008 Port: gnt_id  output  2  index of current or last grantee, registered.
REQ-009 Port: busy  output  1  high whenever state is not IDLE, registered.
REQ-010 Port: timeout  output  1  one-cycle pulse on forced revoke (present only with ARB_TIMEOUT_EN).

Function
REQ-011 The FSM shall have exactly three states: IDLE, GRANT, RECOVER.
REQ-012 IDLE: if inhibit=0 and req!=0 at edge N, winner is the first set req scanning upward from last_id+1 modulo 4; gnt/gnt_id/busy update at edge N, state to GRANT (one-cycle latency from request to visible grant).
REQ-013 IDLE with inhibit=1 or req=0: gnt=0, remain IDLE; requests are not latched.
REQ-014 GRANT: gnt holds steady until rel[gnt_id]=1 is sampled; next edge clears gnt, sets last_id=gnt_id, state to RECOVER.
REQ-015 GRANT: rel from non-granted requesters, req deassertion and inhibit assertion shall not revoke or change the grant.
REQ-016 RECOVER: exactly one cycle with gnt=0, busy=1, then IDLE; requests are not evaluated in RECOVER.
REQ-017 Minimum grant-to-grant spacing is 3 cycles (GRANT, RECOVER, IDLE); the round robin shall give a persistently requesting port a grant within 3 grant slots.
REQ-018 gnt shall never have more than one bit set; gnt_id shall retain its value outside GRANT.

Reset
REQ-019 reset_n=0 sampled at an edge shall force: state IDLE, gnt=0, gnt_id=0, busy=0, timeout=0, last_id=3 (requester 0 has first priority), hold counter=0.
REQ-020 Reset mid-grant shall drop gnt in the same edge, no RECOVER cycle.

Configuration
REQ-021 Macro ARB_TIMEOUT_EN defined: an 8-bit hold counter clears on entry to GRANT, increments each GRANT cycle; if it reaches HOLD_MAX-1 with no valid rel, revoke as REQ-014 and pulse timeout for one cycle coincident with gnt clearing.
REQ-022 Valid rel and timeout in the same cycle: treat as normal release, timeout stays 0.
REQ-023 Macro undefined: no counter, no timeout port, grant held indefinitely until rel.

Structure
REQ-024 Shared package port_arb_pkg shall hold the state enumeration, NUM_REQ=4, ID_W=2 and the HOLD_MAX default.
REQ-025 Combinational sub-module rr_pick4 (inputs req, last_id; outputs valid, winner id) shall implement the rotating priority scan; FSM and registers stay in port_arbiter4.

Verification
REQ-026 Reset then req=0001 at edge 1 -> gnt=0001, gnt_id=0, busy=1 after edge 1; rel=0001 -> gnt=0000 next edge, busy low two edges later.
REQ-027 req=1111 held, each grantee releases one cycle after grant -> grant order 0,1,2,3,0 with grants 3 cycles apart.
REQ-028 inhibit=1 with req=0100 for 10 cycles -> gnt stays 0000; drop inhibit -> gnt=0100 one edge later.
REQ-029 Grant to requester 2, assert rel=1011 (bit 2 clear) -> grant held; then rel=0100 -> grant released.
REQ-030 ARB_TIMEOUT_EN, HOLD_MAX=4, grant with no rel -> gnt clears and timeout=1 for one cycle after 4 GRANT cycles; without macro grant persists 300 cycles.
REQ-031 reset_n=0 mid-grant -> gnt=0000, busy=0 at that edge; next request from requester 3 with 0 also requesting -> requester 0 wins.
